// File: rtl/uart_fifo_receiver_pkg.sv
// Shared constants for the UART FIFO receiver: FSM state encodings,
// oversample points used for the majority vote, and the data width.
// Optional build macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_fifo_receiver_pkg;

    localparam int DATA_W = 8;

    // Oversample counter positions within one bit period (16 ticks per bit)
    localparam logic [3:0] S_MID_A = 4'd7;
    localparam logic [3:0] S_MID_B = 4'd8;
    localparam logic [3:0] S_MID_C = 4'd9;
    localparam logic [3:0] S_LAST  = 4'd15;

    // Receiver FSM encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Two-out-of-three vote used for every bit decision
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo_receiver_sync_fifo.sv
// Show-ahead synchronous FIFO. dout presents the head entry (zero when empty).
// A push while full only succeeds if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because dout is gated by empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_receiver.sv
// UART receive endpoint: 2-FF synchronizer, 16x oversampling with 3-sample
// majority vote, start-glitch rejection, framing-error detection, and a
// byte FIFO drained through a valid/ready handshake.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing plus parity_err pulse).
//
// Handshake: valid is high whenever the FIFO holds a byte and data shows the
// head byte; the byte is consumed on every clock edge where valid && ready.
// ready may be held high or toggled freely; it has no effect while valid = 0.
module uart_fifo_receiver
    import uart_fifo_receiver_pkg::*;
#(
    parameter int TICK_CYCLES    = 260,
    parameter int TICK_WIDTH     = 9,
    parameter int FIFO_LOG_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx,
    output logic [DATA_W-1:0]         data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic [FIFO_LOG_DEPTH:0]   count
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      parity_err
`endif
);

    logic                  rx_meta;
    logic                  rx_s;
    logic [TICK_WIDTH-1:0] tick_cnt;
    logic                  tick;
    logic [2:0]            state;
    logic [3:0]            s;
    logic [2:0]            bit_idx;
    logic [DATA_W-1:0]     shift;
    logic                  smp_a;
    logic                  smp_b;
    logic                  bit_val;
    logic                  stop_decide;
    logic                  push_byte;
    logic                  pop;
    logic                  empty;
    logic                  full;
`ifdef UART_RX_PARITY_EN
    logic                  parity_ok;
`endif

    // Two-stage synchronizer for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TICK_WIDTH'(TICK_CYCLES - 1));

    // Free-running 1/16-bit tick generator
    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    // Third vote is the live sample at s = 9, so the decision lands on that tick
    assign bit_val     = majority3(smp_a, smp_b, rx_s);
    assign stop_decide = tick && (state == ST_STOP) && (s == S_MID_C);
`ifdef UART_RX_PARITY_EN
    assign push_byte   = stop_decide && bit_val && parity_ok;
`else
    assign push_byte   = stop_decide && bit_val;
`endif
    assign pop         = valid && ready;

    // Frame FSM: all progress happens on ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            s       <= '0;
            bit_idx <= '0;
            shift   <= '0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_ok <= 1'b1;
`endif
        end else if (tick) begin
            if (s == S_MID_A) smp_a <= rx_s;
            if (s == S_MID_B) smp_b <= rx_s;
            case (state)
                ST_IDLE: begin
                    s <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    s <= s + 4'd1;
                    if (s == S_MID_C && bit_val) begin
                        state <= ST_IDLE;           // start bit too short: glitch
                    end else if (s == S_LAST) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    s <= s + 4'd1;
                    if (s == S_MID_C) shift <= {bit_val, shift[DATA_W-1:1]};
                    if (s == S_LAST) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    s <= s + 4'd1;
                    if (s == S_MID_C) parity_ok <= ~(^shift ^ bit_val);
                    if (s == S_LAST)  state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    s <= s + 4'd1;
                    // Leaving at mid-stop lets the next start bit arrive early
                    if (s == S_MID_C) state <= bit_val ? ST_IDLE : ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    s <= '0;
                    if (rx_s) state <= ST_IDLE;     // ignore a held-low break line
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Error pulses, one cycle after the stop decision
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_decide && !bit_val;
            overrun   <= push_byte && full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_decide && !parity_ok;
`endif
        end
    end

    sync_fifo #(
        .WIDTH     (DATA_W),
        .LOG_DEPTH (FIFO_LOG_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_byte),
        .pop   (pop),
        .din   (shift),
        .dout  (data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign valid = !empty;

endmodule

// File: doc/uart_fifo_receiver.md
Name: uart_fifo_receiver

Overview:
Robust UART receive endpoint. It pairs with uart_transmitter on the far end of the serial link.
- 16x oversampling, majority-vote bit decisions, start-glitch rejection and framing-error detection.
- Received bytes are buffered in a small FIFO and presented on a valid/ready handshake.
- Sits between the uart_rx pin and consumer logic (command decoders, multibyte assemblers) that may stall.

Parameters:
TICK_CYCLES, 260, clk cycles per 1/16 bit period (bit period = 16*TICK_CYCLES)
TICK_WIDTH, 9, width of tick counter; must satisfy 2**TICK_WIDTH > TICK_CYCLES-1
FIFO_LOG_DEPTH, 3, FIFO depth = 2**FIFO_LOG_DEPTH bytes

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line, idle high
data  output  8  byte at FIFO head; valid only while valid=1
valid  output  1  FIFO non-empty
ready  input  1  consumer accepts head byte when valid&&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good byte dropped, FIFO full
count  output  FIFO_LOG_DEPTH+1  current FIFO occupancy

Behaviour:
- Reset: clock clk; reset is synchronous, active-high.
  - Synchronizer regs = 1, state = IDLE, tick counter = 0, FIFO empty.
  - valid = 0, count = 0, frame_err = 0, overrun = 0, data = 0.
  - Reset mid-frame abandons the partial byte and clears the FIFO.
- Input: 2-FF synchronizer on uart_rx; all decisions use the synchronized value rx_s.
- Tick generator: free-running counter 0..TICK_CYCLES-1; tick = 1 for one clk at terminal count. Sample counter s (4 bits) advances on tick.
- Majority: per bit, rx_s is captured at s = 7, 8, 9. Bit value = majority of 3, decided at the tick where s = 9.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
  - IDLE: on tick with rx_s = 0 → START, s = 0.
  - START: majority = 1 at s = 9 → glitch, back to IDLE. Otherwise stay until s wraps 15→0, then DATA, bit index = 0.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit 7 wraps → STOP (or PARITY when the option is enabled).
  - STOP, decision at s = 9:
    - majority 1 → push byte, go IDLE immediately. This gives early resync tolerance.
    - majority 0 → frame_err pulse, byte discarded, go WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s = 1, then IDLE. No start detection on a held-low (break) line.
- FIFO:
  - Show-ahead: data = head entry.
  - Pop on valid && ready. Push on good stop.
  - Byte visible (valid = 1 when previously empty) on the cycle after the stop decision cycle.
  - Push when full without a simultaneous pop → byte dropped, overrun pulse, FIFO contents unchanged.
  - Push and pop in the same cycle when full → both succeed, no overrun, count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo depth; count ranges 0..2**FIFO_LOG_DEPTH.
- frame_err and overrun are registered pulses, aligned with the decision cycle + 1.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - After DATA, enter PARITY state; one extra bit is sampled with the same majority scheme.
  - Even parity over the 8 data bits plus the parity bit must be 0.
  - On mismatch the byte is discarded (no push), and the parity_err output (1 bit, one-cycle pulse, same timing as frame_err) fires.
  - If parity fails and stop is also bad, both pulses fire.
- Undefined: 8N1 framing only; no PARITY state, no parity_err port.

Decomposition:
- Shared package/header: FSM state encodings (localparams), the sample-point constants 7/8/9 and 15, and the data width 8.
- Sub-module: sync_fifo.
  - Parameters: width and log-depth.
  - Signals: push, pop, din, dout, empty, full, count.
  - The receiver instantiates it with width 8.

Test Plan:
- Send 0x55 then 0xA3 at the exact baud, ready=1 → two valid pulses, data 0x55 then 0xA3, no error pulses.
- Low glitch of 3 ticks on idle line → no valid, no frame_err, FSM returns to IDLE.
- Frame 0x3C with stop bit 0, then line held low for 3 bit times, then a good 0x81 → one frame_err; no byte for 0x3C; exactly one byte 0x81 after line returns high.
- ready=0, send 9 bytes 0x01..0x09 → count reaches 8, overrun pulse on 9th. Then ready=1 drains 0x01..0x08 in order; 0x09 is never seen.
- FIFO full with ready=1 asserted on the same cycle as the 9th byte's push → no overrun, count stays 8, 0x09 later delivered.
- Reset asserted at DATA bit 4 of a frame, released, then 0xF0 sent → FIFO empty after reset, only 0xF0 received. With UART_RX_PARITY_EN, 0xF0 with odd parity bit → parity_err pulse, no byte.
